// File: rtl/div_pkg.sv
// Shared op encodings, FSM states and operand helpers for the RV64M divide front end.
package div_pkg;

  typedef enum logic [2:0] {
    OpDiv   = 3'd0,
    OpRem   = 3'd1,
    OpDivw  = 3'd2,
    OpRemw  = 3'd3,
    OpDivuw = 3'd4,
    OpRemuw = 3'd5,
    OpDivu  = 3'd6,
    OpRemu  = 3'd7
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } div_state_e;

  localparam int unsigned DivLatencyDefault = 66;
  localparam logic [63:0] Min64             = 64'h8000_0000_0000_0000;
  localparam logic [31:0] Min32             = 32'h8000_0000;

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_word(input logic [2:0] op);
    return (op[2:1] == 2'b01) || (op[2:1] == 2'b10);
  endfunction

  function automatic logic op_is_unsup(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  // Word ops are narrowed so that the signed core sees exactly the value the op means.
  function automatic logic [63:0] prep_operand(input logic [2:0] op, input logic [63:0] x);
    logic [63:0] r;
    case (op[2:1])
      2'b01:   r = {{32{x[31]}}, x[31:0]};
      2'b10:   r = {32'd0, x[31:0]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/div_result_fix.sv
// Combinational result fixup: remainder sign restore, quotient/remainder select, word sign-extend.
module div_result_fix
  import div_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        dividend_neg_i,
  input  logic [63:0] quotient_i,
  input  logic [63:0] rem_mag_i,
  output logic [63:0] result_o
);

  logic [63:0] rem_signed;
  logic [63:0] sel;

  always_comb begin
    // Remainder takes the dividend's sign; a zero magnitude negates to zero.
    rem_signed = dividend_neg_i ? (64'd0 - rem_mag_i) : rem_mag_i;
    sel        = op_is_rem(op_i) ? rem_signed : quotient_i;
    result_o   = op_is_word(op_i) ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// RV64M divide front end: resolves corner cases locally, otherwise issues to the
// multi-cycle signed divider core and returns a fixed-up result on a valid/ready response.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DivLatencyDefault,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [63:0] req_a_i,
  input  logic [63:0] req_b_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_data_o,
  output logic        resp_err_o,
  output logic        div_start_o,
  output logic [63:0] div_dividend_o,
  output logic [63:0] div_divisor_o,
  input  logic [63:0] div_quotient_i,
  input  logic [63:0] div_remainder_i
);

  localparam logic [CNT_W-1:0] LatCnt = CNT_W'(DIV_LATENCY);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic             start_q, start_d;
  logic [63:0]      dividend_q, dividend_d;
  logic [63:0]      divisor_q, divisor_d;

  logic [63:0] a_prep, b_prep;
  logic        b_zero, ovf64, ovf32, take_fast;
  logic [63:0] fast_quot, fast_rmag;
  logic        use_core;
  logic [2:0]  fix_op;
  logic        fix_neg;
  logic [63:0] fix_quot, fix_rmag, fix_result;

  always_comb begin
    a_prep    = prep_operand(req_op_i, req_a_i);
    b_prep    = prep_operand(req_op_i, req_b_i);
    b_zero    = (b_prep == 64'd0);
    ovf64     = ((req_op_i == OpDiv) || (req_op_i == OpRem)) &&
                (a_prep == Min64) && (b_prep == '1);
    ovf32     = ((req_op_i == OpDivw) || (req_op_i == OpRemw)) &&
                (req_a_i[31:0] == Min32) && (req_b_i[31:0] == '1);
    take_fast = b_zero || ovf64 || ovf32;
    // Fast-path values are fed as a magnitude so the shared fixup restores the dividend exactly.
    fast_quot = b_zero ? '1 : a_prep;
    fast_rmag = b_zero ? (a_prep[63] ? (64'd0 - a_prep) : a_prep) : 64'd0;
  end

  always_comb begin
    use_core = (state_q == StWait);
    fix_op   = use_core ? op_q : req_op_i;
    fix_neg  = use_core ? dividend_q[63] : a_prep[63];
    fix_quot = use_core ? div_quotient_i : fast_quot;
    fix_rmag = use_core ? div_remainder_i : fast_rmag;
  end

  div_result_fix u_fix (
    .op_i           (fix_op),
    .dividend_neg_i (fix_neg),
    .quotient_i     (fix_quot),
    .rem_mag_i      (fix_rmag),
    .result_o       (fix_result)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    start_d      = 1'b0;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d        = req_op_i;
          req_ready_d = 1'b0;
          if (op_is_unsup(req_op_i)) begin
            resp_err_d   = 1'b1;
            resp_data_d  = 64'd0;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else if (take_fast) begin
            resp_err_d   = 1'b0;
            resp_data_d  = fix_result;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else begin
            dividend_d = a_prep;
            divisor_d  = b_prep;
            start_d    = 1'b1;
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = LatCnt;
        state_d = StWait;
      end
      StWait: begin
        // The core's done flag is sticky, so completion is timed by our own counter.
        if (cnt_q == '0) begin
          resp_data_d  = fix_result;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= 3'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 64'd0;
      resp_err_q   <= 1'b0;
      start_q      <= 1'b0;
      dividend_q   <= 64'd0;
      divisor_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      start_q      <= start_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign div_start_o    = start_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural fixed-latency signed divider core.
module tb_div_issue_ctrl;

  localparam int unsigned Lat  = 66;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Min  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] Junk = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] Neg2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] Neg3 = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] Neg7 = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] Neg9 = 64'hFFFF_FFFF_FFFF_FFF7;
  localparam logic [63:0] N14  = 64'hFFFF_FFFF_FFFF_FFF2;
  localparam logic [63:0] N100 = 64'hFFFF_FFFF_FFFF_FF9C;

  logic        clk;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [63:0] req_a_i;
  logic [63:0] req_b_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        div_start_o;
  logic [63:0] div_dividend_o;
  logic [63:0] div_divisor_o;
  logic [63:0] div_quotient_i;
  logic [63:0] div_remainder_i;

  div_issue_ctrl dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_op_i        (req_op_i),
    .req_a_i         (req_a_i),
    .req_b_i         (req_b_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_data_o     (resp_data_o),
    .resp_err_o      (resp_err_o),
    .div_start_o     (div_start_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] data;
    logic        err;
    logic        fast;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic [31:0] lat;
    logic [31:0] starts;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Core model: results appear DIV_LATENCY edges after the start sample, garbage before.
  function automatic logic [63:0] ref_quot(input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return Ones;
    if (a == Min && b == Ones) return Min;
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [63:0] ref_rmag(input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] r;
    if (b == 64'd0) r = a;
    else if (a == Min && b == Ones) r = 64'sd0;
    else r = $signed(a) % $signed(b);
    return r[63] ? (64'd0 - r) : r;
  endfunction

  logic [63:0] m_q, m_r;
  int unsigned m_cnt;
  int unsigned start_cnt = 0;

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      m_cnt <= 0;
      m_q   <= 64'd0;
      m_r   <= 64'd0;
    end else if (div_start_o) begin
      m_q   <= ref_quot(div_dividend_o, div_divisor_o);
      m_r   <= ref_rmag(div_dividend_o, div_divisor_o);
      m_cnt <= Lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) if (div_start_o) start_cnt <= start_cnt + 1;

  assign div_quotient_i  = (m_cnt == 0) ? m_q : Junk;
  assign div_remainder_i = (m_cnt == 0) ? m_r : Junk;

  function automatic vec_t mk(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] data, input logic err, input logic fast);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.data = data; v.err = err; v.fast = fast;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready_o) begin
      total++;
      bad++;
      $display("FAIL %s ready timeout: req_ready_o=%b want 1", name, req_ready_o);
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk); resp_ready_i = 1'b1;
    @(posedge clk); #1 resp_ready_i = 1'b0;
    chk({name, " after handshake valid/ready"}, {62'd0, resp_valid_o, req_ready_o}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t        e;
    int unsigned s0;
    int unsigned lat;
    bit          got;
    e.data   = v.data;
    e.err    = v.err;
    e.lat    = v.fast ? 32'd0 : 32'(Lat + 2);
    e.starts = v.fast ? 32'd0 : 32'd1;
    wait_ready(name);
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = v.op; req_a_i = v.a; req_b_i = v.b;
    s0 = start_cnt;
    @(posedge clk); exp_q.push_back(e);
    #1 req_valid_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s resp timeout: resp_valid_o=%b want 1", name, resp_valid_o);
      return;
    end
    chk({name, " data"}, resp_data_o, e.data);
    chk({name, " err"}, {63'd0, resp_err_o}, {63'd0, e.err});
    chk({name, " latency"}, 64'(lat), 64'(e.lat));
    chk({name, " starts"}, 64'(start_cnt - s0), 64'(e.starts));
    handshake(name);
  endtask

  initial begin
    exp_t e;
    int   stale;
    int unsigned s0;

    reset_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    req_op_i = 3'd0; req_a_i = 64'd0; req_b_i = 64'd0;

    // op, a, b, expected data, expected err, fast path
    vecs.push_back(mk(3'd0, 64'd100, Neg7, N14, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, N100, 64'd7, Neg2, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 64'd5, 64'd0, Ones, 1'b0, 1'b1));
    vecs.push_back(mk(3'd1, 64'd5, 64'd0, 64'd5, 1'b0, 1'b1));
    vecs.push_back(mk(3'd0, Min, Ones, Min, 1'b0, 1'b1));
    vecs.push_back(mk(3'd1, Min, Ones, 64'd0, 1'b0, 1'b1));
    vecs.push_back(mk(3'd3, 64'h0000_0000_8000_0000, Ones, 64'd0, 1'b0, 1'b1));
    vecs.push_back(mk(3'd2, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                      64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(3'd4, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(3'd6, 64'd100, 64'd7, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(3'd7, 64'd100, 64'd7, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(3'd2, 64'h0000_0001_FFFF_FFF9, 64'd2, Neg3, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 64'h0000_0001_FFFF_FFF9, 64'd2, Ones, 1'b0, 1'b0));
    vecs.push_back(mk(3'd4, Ones, 64'd1, Ones, 1'b0, 1'b0));
    vecs.push_back(mk(3'd5, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_8000_0000,
                      64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, Neg9, 64'd3, 64'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd2, 64'd5, 64'h0000_0001_0000_0000, Ones, 1'b0, 1'b1));
    vecs.push_back(mk(3'd3, 64'h0000_0001_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1));
    vecs.push_back(mk(3'd5, Ones, 64'd0, Ones, 1'b0, 1'b1));
    vecs.push_back(mk(3'd0, N100, Neg7, 64'd14, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, 64'd100, Neg7, 64'd2, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("reset resp_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("reset resp_data", resp_data_o, 64'd0);
    chk("reset err/start", {62'd0, resp_err_o, div_start_o}, 64'd0);
    chk("reset dividend", div_dividend_o, 64'd0);
    chk("reset divisor", div_divisor_o, 64'd0);
    @(negedge clk); reset_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response backpressure: everything must hold while resp_ready_i stays low.
    wait_ready("bp");
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 3'd0; req_a_i = 64'd5; req_b_i = 64'd0;
    @(posedge clk); exp_q.push_back('{data: Ones, err: 1'b0, lat: 32'd0, starts: 32'd0});
    #1 req_valid_i = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp data c%0d", i), resp_data_o, e.data);
      chk($sformatf("bp valid/ready/err c%0d", i),
          {61'd0, resp_valid_o, req_ready_o, resp_err_o}, {61'd0, 1'b1, 1'b0, e.err});
      @(posedge clk); #1;
    end
    handshake("bp");

    // Reset while the core is busy.
    wait_ready("rst");
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 3'd0; req_a_i = 64'd100; req_b_i = Neg7;
    @(posedge clk); #1 req_valid_i = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("rst busy resp_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("rst busy dividend", div_dividend_o, 64'd100);
    reset_i = 1'b0;
    #2;
    chk("midrst req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("midrst resp_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("midrst resp_data", resp_data_o, 64'd0);
    chk("midrst err/start", {62'd0, resp_err_o, div_start_o}, 64'd0);
    chk("midrst dividend", div_dividend_o, 64'd0);
    chk("midrst divisor", div_divisor_o, 64'd0);
    @(negedge clk); reset_i = 1'b1;
    stale = 0;
    s0 = start_cnt;
    repeat (80) begin
      @(posedge clk); #1;
      if (resp_valid_o) stale++;
    end
    chk("post-rst stale responses", 64'(stale), 64'd0);
    chk("post-rst stray starts", 64'(start_cnt - s0), 64'd0);
    run_vec(mk(3'd0, 64'd9, 64'd3, 64'd3, 1'b0, 1'b0), "post-rst div 9/3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
